mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 164 ++++++++++++++++
 tb/tb_mem_stage.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds one instruction, issues its data-RAM request,
// waits for the read data and presents the result to write-back and forwarding.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        exe_valid,
  input  logic [31:0] exe_pc,
  input  logic [4:0]  exe_rd,
  input  logic        exe_ref_we,
  input  logic        exe_res_from_dram,
  input  logic        exe_dram_re,
  input  logic        exe_dram_we,
  input  logic [31:0] exe_alu_result,
  input  logic [31:0] exe_dram_wdata,
  input  logic [1:0]  exe_rdram_num,
  input  logic [1:0]  exe_wdram_num,
  input  logic        exe_rdram_need_zero_extend,
  input  logic        exe_rdram_need_signed_extend,
  output logic        mem_allowin,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  output logic        ms_to_ws_valid,
  output logic [31:0] ws_pc,
  output logic [4:0]  ws_rd,
  output logic        ws_we,
  output logic [31:0] ws_wdata,
  input  logic        wb_allowin,
  output logic [4:0]  ms_fwd_rd,
  output logic [31:0] ms_fwd_data,
  output logic        ms_fwd_busy,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_r, alu_r, sdata_r, rbuf;
  logic [4:0]  rd_r;
  logic [1:0]  rnum_r, wnum_r;
  logic        ref_we_r, from_dram_r, re_r, we_r, zext_r, sext_r;
  logic        accept;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  // Handshakes: a transfer happens on a cycle where valid and ready are both high
  // (exe_valid/mem_allowin, data_sram_req/addr_ok, ms_to_ws_valid/wb_allowin);
  // data_ok is a single-cycle response that only counts while in WAIT.
  assign accept = exe_valid & mem_allowin;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc_r        <= '0;
      rd_r        <= '0;
      ref_we_r    <= 1'b0;
      from_dram_r <= 1'b0;
      re_r        <= 1'b0;
      we_r        <= 1'b0;
      alu_r       <= '0;
      sdata_r     <= '0;
      rnum_r      <= '0;
      wnum_r      <= '0;
      zext_r      <= 1'b0;
      sext_r      <= 1'b0;
      rbuf        <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        pc_r        <= exe_pc;
        rd_r        <= exe_rd;
        ref_we_r    <= exe_ref_we;
        from_dram_r <= exe_res_from_dram;
        re_r        <= exe_dram_re;
        we_r        <= exe_dram_we;
        alu_r       <= exe_alu_result;
        sdata_r     <= exe_dram_wdata;
        rnum_r      <= exe_rdram_num;
        wnum_r      <= exe_wdram_num;
        zext_r      <= exe_rdram_need_zero_extend;
        sext_r      <= exe_rdram_need_signed_extend;
      end
      if (state == WAIT && data_sram_data_ok) rbuf <= data_sram_rdata;
    end
  end

  always_comb begin
    state_nxt   = state;
    mem_allowin = (state == IDLE) | ((state == DONE) & wb_allowin);
    case (state)
      IDLE: if (exe_valid) state_nxt = (exe_dram_re | exe_dram_we) ? REQ : DONE;
      REQ:  if (data_sram_addr_ok) state_nxt = WAIT;
      WAIT: if (data_sram_data_ok) state_nxt = DONE;
      DONE: begin
        if (wb_allowin) begin
          if (exe_valid) state_nxt = (exe_dram_re | exe_dram_we) ? REQ : DONE;
          else           state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Store lane enables and replicated write data; loads never write.
  always_comb begin
    data_sram_wstrb = 4'b0000;
    data_sram_wdata = sdata_r;
    if (we_r) begin
      case (wnum_r)
        2'b00: begin
          data_sram_wstrb = 4'b0001 << alu_r[1:0];
          data_sram_wdata = {4{sdata_r[7:0]}};
        end
        2'b01: begin
          data_sram_wstrb = alu_r[1] ? 4'b1100 : 4'b0011;
          data_sram_wdata = {2{sdata_r[15:0]}};
        end
        default: data_sram_wstrb = 4'b1111;
      endcase
    end
  end

  // Signed extension wins when both extension flags are set.
  always_comb begin
    ld_byte = rbuf[{alu_r[1:0], 3'b000} +: 8];
    ld_half = alu_r[1] ? rbuf[31:16] : rbuf[15:0];
    ld_ext  = rbuf;
    case (rnum_r)
      2'b00: begin
        case ({sext_r, zext_r})
          2'b10, 2'b11: ld_ext = {{24{ld_byte[7]}}, ld_byte};
          default:      ld_ext = {24'b0, ld_byte};
        endcase
      end
      2'b01: begin
        case ({sext_r, zext_r})
          2'b10, 2'b11: ld_ext = {{16{ld_half[15]}}, ld_half};
          default:      ld_ext = {16'b0, ld_half};
        endcase
      end
      default: ld_ext = rbuf;
    endcase
  end

  assign data_sram_req  = (state == REQ) & (re_r | we_r);
  assign data_sram_wr   = we_r;
  assign data_sram_addr = alu_r;
  assign ms_to_ws_valid = (state == DONE);
  assign ws_pc          = pc_r;
  assign ws_rd          = rd_r;
  assign ws_we          = ref_we_r;
  assign ws_wdata       = from_dram_r ? ld_ext : alu_r;
  assign ms_fwd_rd      = ((state != IDLE) && ref_we_r && (rd_r != 5'd0)) ? rd_r : 5'd0;
  assign ms_fwd_data    = ws_wdata;
  assign ms_fwd_busy    = (state != IDLE) & from_dram_r & (state != DONE);
  assign dbg_state      = state;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized ops against
// an arithmetic reference model of load extraction and store lane/data generation.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        exe_valid;
  logic [31:0] exe_pc;
  logic [4:0]  exe_rd;
  logic        exe_ref_we, exe_res_from_dram, exe_dram_re, exe_dram_we;
  logic [31:0] exe_alu_result, exe_dram_wdata;
  logic [1:0]  exe_rdram_num, exe_wdram_num;
  logic        exe_rdram_need_zero_extend, exe_rdram_need_signed_extend;
  logic        mem_allowin;
  logic        data_sram_req, data_sram_wr;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        ms_to_ws_valid;
  logic [31:0] ws_pc;
  logic [4:0]  ws_rd;
  logic        ws_we;
  logic [31:0] ws_wdata;
  logic        wb_allowin;
  logic [4:0]  ms_fwd_rd;
  logic [31:0] ms_fwd_data;
  logic        ms_fwd_busy;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .exe_valid(exe_valid), .exe_pc(exe_pc), .exe_rd(exe_rd), .exe_ref_we(exe_ref_we),
    .exe_res_from_dram(exe_res_from_dram), .exe_dram_re(exe_dram_re), .exe_dram_we(exe_dram_we),
    .exe_alu_result(exe_alu_result), .exe_dram_wdata(exe_dram_wdata),
    .exe_rdram_num(exe_rdram_num), .exe_wdram_num(exe_wdram_num),
    .exe_rdram_need_zero_extend(exe_rdram_need_zero_extend),
    .exe_rdram_need_signed_extend(exe_rdram_need_signed_extend),
    .mem_allowin(mem_allowin),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .ms_to_ws_valid(ms_to_ws_valid), .ws_pc(ws_pc), .ws_rd(ws_rd), .ws_we(ws_we),
    .ws_wdata(ws_wdata), .wb_allowin(wb_allowin),
    .ms_fwd_rd(ms_fwd_rd), .ms_fwd_data(ms_fwd_data), .ms_fwd_busy(ms_fwd_busy),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // reference model
  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [31:0] rdata,
                                             input logic [1:0] num, input bit sext);
    logic [31:0] v;
    if (num == 2'b00) begin
      v = (rdata >> (8 * (addr % 4))) & 32'hFF;
      if (sext && v >= 128) v = v - 256;
    end else if (num == 2'b01) begin
      v = (rdata >> (((addr % 4) >= 2) ? 16 : 0)) & 32'hFFFF;
      if (sext && v >= 32768) v = v - 65536;
    end else begin
      v = rdata;
    end
    return v;
  endfunction

  function automatic logic [3:0] model_wstrb(input logic [31:0] addr, input logic [1:0] num);
    if (num == 2'b00) return 4'b0001 << (addr % 4);
    if (num == 2'b01) return ((addr % 4) >= 2) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] model_sdata(input logic [31:0] w, input logic [1:0] num);
    if (num == 2'b00) return (w & 32'hFF) * 32'h01010101;
    if (num == 2'b01) return (w & 32'hFFFF) * 32'h00010001;
    return w;
  endfunction

  // driver tasks
  task automatic drive_idle_inputs();
    exe_valid = 1'b0; exe_pc = '0; exe_rd = '0; exe_ref_we = 1'b0; exe_res_from_dram = 1'b0;
    exe_dram_re = 1'b0; exe_dram_we = 1'b0; exe_alu_result = '0; exe_dram_wdata = '0;
    exe_rdram_num = '0; exe_wdram_num = '0;
    exe_rdram_need_zero_extend = 1'b0; exe_rdram_need_signed_extend = 1'b0;
    data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = '0;
  endtask

  task automatic present(input bit is_ld, input bit is_st, input logic [31:0] pc,
                         input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] sd,
                         input logic [1:0] num, input bit sext, input bit zext);
    exe_valid = 1'b1; exe_pc = pc; exe_rd = rd; exe_ref_we = !is_st;
    exe_res_from_dram = is_ld; exe_dram_re = is_ld; exe_dram_we = is_st;
    exe_alu_result = alu; exe_dram_wdata = sd;
    exe_rdram_num = is_ld ? num : 2'($urandom_range(0, 3));
    exe_wdram_num = is_st ? num : 2'($urandom_range(0, 3));
    exe_rdram_need_signed_extend = sext; exe_rdram_need_zero_extend = zext;
  endtask

  task automatic scramble_exe();
    exe_valid = 1'b0; exe_pc = $urandom; exe_rd = 5'($urandom); exe_alu_result = $urandom;
    exe_dram_wdata = $urandom; exe_ref_we = 1'($urandom); exe_res_from_dram = 1'($urandom);
    exe_rdram_num = 2'($urandom); exe_wdram_num = 2'($urandom);
  endtask

  // One full op from an idle stage with wb_allowin high, ending back in idle.
  task automatic do_op(input string nm, input bit is_ld, input bit is_st, input logic [31:0] pc,
                       input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] sd,
                       input logic [1:0] num, input bit sext, input bit zext,
                       input logic [31:0] rdata, input int ao_dly, input int do_dly);
    logic [31:0] exp_ws;
    logic [4:0]  exp_frd;
    logic [3:0]  exp_strb;
    exp_ws   = is_ld ? model_load(alu, rdata, num, sext) : alu;
    exp_frd  = (!is_st && rd != 0) ? rd : 5'd0;
    exp_strb = is_st ? model_wstrb(alu, num) : 4'b0000;
    wb_allowin = 1'b1;
    present(is_ld, is_st, pc, rd, alu, sd, num, sext, zext);
    step();
    scramble_exe();
    if (is_ld || is_st) begin
      for (int i = 0; i <= ao_dly; i++) begin
        n_checks++;
        if (data_sram_req !== 1'b1 || data_sram_addr !== alu || data_sram_wr !== is_st ||
            data_sram_wstrb !== exp_strb || ms_to_ws_valid !== 1'b0 || ms_fwd_busy !== is_ld ||
            ms_fwd_rd !== exp_frd) begin
          n_fail++;
          $display("FAIL %s req phase: req=%b addr=%h wr=%b strb=%b v=%b busy=%b frd=%0d expected req=1 addr=%h wr=%b strb=%b v=0 busy=%b frd=%0d",
                   nm, data_sram_req, data_sram_addr, data_sram_wr, data_sram_wstrb, ms_to_ws_valid,
                   ms_fwd_busy, ms_fwd_rd, alu, is_st, exp_strb, is_ld, exp_frd);
        end
        if (is_st) begin
          n_checks++;
          if (data_sram_wdata !== model_sdata(sd, num)) begin
            n_fail++;
            $display("FAIL %s store data: got %h expected %h", nm, data_sram_wdata, model_sdata(sd, num));
          end
        end
        data_sram_addr_ok = (i == ao_dly);
        data_sram_data_ok = (i == ao_dly) ? 1'b0 : 1'($urandom_range(0, 1));
        data_sram_rdata   = $urandom;
        step();
      end
      data_sram_addr_ok = 1'b0;
      for (int i = 0; i <= do_dly; i++) begin
        n_checks++;
        if (data_sram_req !== 1'b0 || ms_to_ws_valid !== 1'b0 || ms_fwd_busy !== is_ld) begin
          n_fail++;
          $display("FAIL %s wait phase: req=%b v=%b busy=%b expected req=0 v=0 busy=%b",
                   nm, data_sram_req, ms_to_ws_valid, ms_fwd_busy, is_ld);
        end
        data_sram_data_ok = (i == do_dly);
        data_sram_addr_ok = 1'($urandom_range(0, 1));
        data_sram_rdata   = (i == do_dly) ? rdata : $urandom;
        step();
      end
      data_sram_data_ok = 1'b1;
      data_sram_addr_ok = 1'b1;
      data_sram_rdata   = $urandom;
    end
    n_checks++;
    if (ms_to_ws_valid !== 1'b1 || ws_wdata !== exp_ws || ws_we !== !is_st || ws_rd !== rd ||
        ws_pc !== pc || ms_fwd_rd !== exp_frd || ms_fwd_data !== exp_ws || ms_fwd_busy !== 1'b0 ||
        data_sram_req !== 1'b0 || mem_allowin !== 1'b1) begin
      n_fail++;
      $display("FAIL %s done: v=%b wdata=%h we=%b rd=%0d pc=%h frd=%0d fdata=%h busy=%b req=%b allowin=%b expected v=1 wdata=%h we=%b rd=%0d pc=%h frd=%0d busy=0 req=0 allowin=1",
               nm, ms_to_ws_valid, ws_wdata, ws_we, ws_rd, ws_pc, ms_fwd_rd, ms_fwd_data,
               ms_fwd_busy, data_sram_req, mem_allowin, exp_ws, !is_st, rd, pc, exp_frd);
    end
    step();
    data_sram_data_ok = 1'b0;
    data_sram_addr_ok = 1'b0;
    n_checks++;
    if (ms_to_ws_valid !== 1'b0 || mem_allowin !== 1'b1 || ms_fwd_rd !== 5'd0 || data_sram_req !== 1'b0) begin
      n_fail++;
      $display("FAIL %s back to idle: v=%b allowin=%b frd=%0d req=%b expected v=0 allowin=1 frd=0 req=0",
               nm, ms_to_ws_valid, mem_allowin, ms_fwd_rd, data_sram_req);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle_inputs();
    wb_allowin = 1'b1;
    step();
    step();
    n_checks++;
    if (data_sram_req !== 1'b0 || ms_to_ws_valid !== 1'b0 || mem_allowin !== 1'b1 ||
        ms_fwd_rd !== 5'd0 || ms_fwd_busy !== 1'b0 || ws_wdata !== 32'd0 || data_sram_addr !== 32'd0) begin
      n_fail++;
      $display("FAIL reset: req=%b v=%b allowin=%b frd=%0d busy=%b wdata=%h addr=%h expected 0 0 1 0 0 0 0",
               data_sram_req, ms_to_ws_valid, mem_allowin, ms_fwd_rd, ms_fwd_busy, ws_wdata, data_sram_addr);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_alu();
    do_op("alu_rd5", 0, 0, 32'h1c00_0000, 5'd5, 32'h1234, 32'h0, 2'b10, 0, 0, 32'h0, 0, 0);
    do_op("alu_rd0", 0, 0, 32'h1c00_0004, 5'd0, 32'hCAFE_F00D, 32'h0, 2'b10, 0, 0, 32'h0, 0, 0);
  endtask

  task automatic test_loads();
    do_op("ld_b_signed", 1, 0, 32'h1c00_0010, 5'd7, 32'h1003, 32'h0, 2'b00, 1, 0, 32'h80FFFFFF, 2, 0);
    do_op("ld_hu", 1, 0, 32'h1c00_0014, 5'd8, 32'h2002, 32'h0, 2'b01, 0, 1, 32'hBEEF0000, 1, 1);
    do_op("ld_bu_lane1", 1, 0, 32'h1c00_0018, 5'd9, 32'h2001, 32'h0, 2'b00, 0, 1, 32'h1122F344, 0, 0);
    do_op("ld_h_sign_lo", 1, 0, 32'h1c00_001c, 5'd10, 32'h2001, 32'h0, 2'b01, 1, 1, 32'h0000_8001, 0, 2);
    do_op("ld_w_unaligned", 1, 0, 32'h1c00_0020, 5'd11, 32'h2003, 32'h0, 2'b11, 1, 0, 32'h89AB_CDEF, 0, 0);
  endtask

  task automatic test_stores();
    do_op("st_h", 0, 1, 32'h1c00_0030, 5'd3, 32'h3002, 32'h0000ABCD, 2'b01, 0, 0, 32'h0, 0, 0);
    do_op("st_b_lane3", 0, 1, 32'h1c00_0034, 5'd4, 32'h3003, 32'h1234_5678, 2'b00, 0, 0, 32'h0, 1, 0);
    do_op("st_w", 0, 1, 32'h1c00_0038, 5'd6, 32'h3001, 32'hDEAD_BEEF, 2'b10, 0, 0, 32'h0, 0, 1);
  endtask

  task automatic test_stall_and_back_to_back();
    wb_allowin = 1'b0;
    present(0, 0, 32'h1c00_0100, 5'd12, 32'h5555_0001, 32'h0, 2'b10, 0, 0);
    step();
    exe_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (ms_to_ws_valid !== 1'b1 || mem_allowin !== 1'b0 || ws_wdata !== 32'h5555_0001 ||
          ws_rd !== 5'd12 || ws_pc !== 32'h1c00_0100 || ms_fwd_rd !== 5'd12 || ws_we !== 1'b1) begin
        n_fail++;
        $display("FAIL stall cycle %0d: v=%b allowin=%b wdata=%h rd=%0d pc=%h frd=%0d we=%b expected 1 0 55550001 12 1c000100 12 1",
                 i, ms_to_ws_valid, mem_allowin, ws_wdata, ws_rd, ws_pc, ms_fwd_rd, ws_we);
      end
      exe_valid = (i == 2);
      exe_alu_result = $urandom;
      step();
      exe_valid = 1'b0;
    end
    wb_allowin = 1'b1;
    present(0, 0, 32'h1c00_0104, 5'd13, 32'h6666_0002, 32'h0, 2'b10, 0, 0);
    #1;
    n_checks++;
    if (mem_allowin !== 1'b1) begin
      n_fail++;
      $display("FAIL stall release allowin: got %b expected 1", mem_allowin);
    end
    step();
    scramble_exe();
    n_checks++;
    if (ms_to_ws_valid !== 1'b1 || ws_wdata !== 32'h6666_0002 || ws_rd !== 5'd13 || ws_pc !== 32'h1c00_0104) begin
      n_fail++;
      $display("FAIL back_to_back: v=%b wdata=%h rd=%0d pc=%h expected 1 66660002 13 1c000104",
               ms_to_ws_valid, ws_wdata, ws_rd, ws_pc);
    end
    step();
    n_checks++;
    if (ms_to_ws_valid !== 1'b0 || mem_allowin !== 1'b1) begin
      n_fail++;
      $display("FAIL back_to_back drain: v=%b allowin=%b expected 0 1", ms_to_ws_valid, mem_allowin);
    end
  endtask

  task automatic test_reset_in_wait();
    wb_allowin = 1'b1;
    present(1, 0, 32'h1c00_0200, 5'd14, 32'h40, 32'h0, 2'b10, 0, 0);
    step();
    scramble_exe();
    data_sram_addr_ok = 1'b1;
    step();
    data_sram_addr_ok = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h1357_9BDF;
    step();
    data_sram_data_ok = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (ms_to_ws_valid !== 1'b0 || data_sram_req !== 1'b0 || mem_allowin !== 1'b1 ||
          ms_fwd_busy !== 1'b0 || ms_fwd_rd !== 5'd0) begin
        n_fail++;
        $display("FAIL reset_in_wait %0d: v=%b req=%b allowin=%b busy=%b frd=%0d expected 0 0 1 0 0",
                 i, ms_to_ws_valid, data_sram_req, mem_allowin, ms_fwd_busy, ms_fwd_rd);
      end
      step();
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int kind;
      kind = $urandom_range(0, 2);
      do_op($sformatf("rand%0d", n), kind == 1, kind == 2, $urandom, 5'($urandom),
            $urandom, $urandom, 2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
            $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_loads();
    test_stores();
    test_stall_and_back_to_back();
    test_reset_in_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
